memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter ADDR_W, default 11, gives data memory depth 2^ADDR_W 16-bit words; only Address[ADDR_W-1:0] is used.
REQ-002 clk  in  1  single clock; all state updates occur on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 Valid_In  in  1  the EX/MEM buffer holds a live instruction.
REQ-005 Data  in  32  store data, or the PC to push ({16'b0,value} otherwise).
REQ-006 Address  in  32  word address: the stack pointer for SP ops, the operand otherwise.
REQ-007 MR, MW, WB, SP, SPOP, JWSP, Stack_PC, Stack_Flags  in  1 each  EX/MEM control bits.
REQ-008 WB_Address  in  3  destination register.
REQ-009 Final_Flags  in  3  flags as {NF,CF,ZF}.
REQ-010 Stall  out  1  holds the EX/MEM buffer and all upstream stages.
REQ-011 SP_Extra  out  1  one-cycle pulse requesting one further SP step: decrement on push, increment on pop.
REQ-012 WB_Out / WB_Address_Out / WB_Data  out  1/3/16  MEM/WB register contents.
REQ-013 PC_Load / PC_Out  out  1/32  popped return PC, valid for one cycle.
REQ-014 MEM_Stack_Flags / Flags_From_Memory  out  1/3  popped flags, valid for one cycle.

Function
REQ-015 Storage SHALL be a word RAM with synchronous write and asynchronous read.
REQ-016 FSM states: IDLE, PUSH_LO, POP_HI.
REQ-017 In IDLE, an instruction is accepted when Valid_In=1.
REQ-018 Plain load (MR=1, Stack_PC=0, Stack_Flags=0) SHALL register WB_Data=mem[Address] one edge later.
REQ-019 Plain store (MW=1, no stack type) SHALL write Data[15:0] at the accepting edge.
REQ-020 Plain stores and loads complete in a single cycle with Stall=0.
REQ-021 Non-memory ops SHALL register WB_Data=Data[15:0].
REQ-022 WB_Out and WB_Address_Out are registered copies of the inputs for every accepted instruction.
REQ-023 WB_Out=0 while Valid_In=0 or Stall=1.
REQ-024 PC push (MW & Stack_PC), cycle 1 in IDLE: write Data[31:16] at A, raise Stall=1, go to PUSH_LO.
REQ-025 PC push, cycle 2 in PUSH_LO: write Data[15:0] at A-1, raise SP_Extra, drop Stall, return to IDLE.
REQ-026 PC pop (MR & Stack_PC), cycle 1 in IDLE: latch lo=mem[A], raise Stall=1, go to POP_HI.
REQ-027 PC pop, cycle 2 in POP_HI: read hi=mem[A+1], raise SP_Extra, drop Stall, return to IDLE.
REQ-028 After a PC pop, the next edge SHALL drive PC_Load=1 and PC_Out={hi,lo} for one cycle.
REQ-029 Flags push (MW & Stack_Flags) SHALL write {13'b0,Final_Flags} at A in a single cycle.
REQ-030 Flags pop (MR & Stack_Flags) SHALL give MEM_Stack_Flags=1 and Flags_From_Memory=mem[A][2:0] one edge later, for one cycle.
REQ-031 Address arithmetic A±1 SHALL wrap modulo 2^ADDR_W: a push with A=0 writes its low word at 2^ADDR_W-1.
REQ-032 MR and MW both set SHALL be treated as a store, with MW taking priority.
REQ-033 Stack_PC and Stack_Flags both set SHALL be treated as Stack_PC.
REQ-034 Inputs SHALL be ignored in PUSH_LO and POP_HI, because upstream is stalled.
REQ-035 Valid_In=0 in IDLE SHALL produce no write and leave all pulse outputs at 0.

Reset
REQ-036 On rst_n=0, immediately and asynchronously: state=IDLE.
REQ-037 Also on rst_n=0, all outputs return to 0: Stall, SP_Extra, WB_Out, WB_Address_Out, WB_Data, PC_Load, PC_Out, MEM_Stack_Flags, Flags_From_Memory.
REQ-038 Reset mid-push SHALL abandon the second word; the first word already written stays in memory.
REQ-039 Reset does not clear RAM contents.

Structure
REQ-040 A shared package SHALL hold the FSM state encoding, the {NF,CF,ZF} bit indices and the default ADDR_W.
REQ-041 The RAM SHALL be one sub-module, data_memory (synchronous write, asynchronous read, one port).
REQ-042 The FSM, address adder and MEM/WB registers live in memory_stage.

Verification
REQ-043 Store then load: store Data=0x0000BEEF at A=5 (MW=1), then load A=5 (MR=1, WB=1, WB_Address=3) -> WB_Data=0xBEEF, WB_Address_Out=3 one edge later, Stall never high.
REQ-044 PC push then pop:
- Push Data=0x0001_2345 at A=0x7FF (ADDR_W=11) -> mem[0x7FF]=0x0001, mem[0x7FE]=0x2345, Stall high 1 cycle, SP_Extra pulse.
- Pop with A=0x7FE -> PC_Load=1, PC_Out=0x00012345.
REQ-045 Wrap: PC push at A=0 with Data=0xAAAA5555 -> mem[0]=0xAAAA, mem[0x7FF]=0x5555.
REQ-046 Flags: push Final_Flags=3'b101 at A=10, then pop at A=10 -> MEM_Stack_Flags=1 for one cycle, Flags_From_Memory=3'b101.
REQ-047 Reset mid-operation: assert rst_n=0 in PUSH_LO -> Stall=0 and state=IDLE immediately; mem[A-1] unchanged; the next load works normally.
REQ-048 Bubble: Valid_In=0 with MW=1 -> no RAM change, WB_Out=0.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: shared FSM encoding, flag bit positions and default RAM depth.
// Revision 1.0
`default_nettype none

package memory_stage_pkg;

    localparam int ADDR_W_DEF = 11;

    // Flags travel as {NF,CF,ZF}
    localparam int ZF_BIT = 0;
    localparam int CF_BIT = 1;
    localparam int NF_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PUSH_LO = 2'd1,
        ST_POP_HI  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/memory_stage_data_memory.sv
// data_memory: single-port 16-bit word RAM, synchronous write, asynchronous read.
// Revision 1.0
`default_nettype none

module data_memory
    import memory_stage_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [15:0]       i_wdata,
    output logic [15:0]       o_rdata
);

    logic [15:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/memory_stage.sv
// memory_stage: MEM pipeline stage with two-cycle PC push/pop and MEM/WB registers.
// Revision 1.0
`default_nettype none

module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Valid_In,
    input  logic [31:0] Data,
    input  logic [31:0] Address,
    input  logic        MR,
    input  logic        MW,
    input  logic        WB,
    input  logic        SP,
    input  logic        SPOP,
    input  logic        JWSP,
    input  logic        Stack_PC,
    input  logic        Stack_Flags,
    input  logic [2:0]  WB_Address,
    input  logic [2:0]  Final_Flags,
    output logic        Stall,
    output logic        SP_Extra,
    output logic        WB_Out,
    output logic [2:0]  WB_Address_Out,
    output logic [15:0] WB_Data,
    output logic        PC_Load,
    output logic [31:0] PC_Out,
    output logic        MEM_Stack_Flags,
    output logic [2:0]  Flags_From_Memory
);

    localparam logic [ADDR_W-1:0] c_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_dlo;
    logic [15:0]       r_mlo;
    logic              r_wb;
    logic [2:0]        r_wba;

    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [15:0]       w_wdata;
    logic [15:0]       w_rdata;
    logic              w_pc_op;
    logic              w_unused;

    assign w_pc_op  = Stack_PC & (MR | MW);
    assign w_unused = ^{SP, SPOP, JWSP, Address[31:ADDR_W]};

    // The single RAM port is steered by the state: operand in IDLE, A-1 / A+1 for second words
    always_comb begin
        w_we    = 1'b0;
        w_addr  = Address[ADDR_W-1:0];
        w_wdata = Data[15:0];
        case (r_state)
            ST_IDLE: begin
                if (Valid_In && MW) begin
                    w_we = 1'b1;
                    if (Stack_PC) begin
                        w_wdata = Data[31:16];
                    end else if (Stack_Flags) begin
                        w_wdata = {13'b0, Final_Flags};
                    end
                end
            end
            ST_PUSH_LO: begin
                w_we    = 1'b1;
                w_addr  = r_addr - c_one;
                w_wdata = r_dlo;
            end
            ST_POP_HI: begin
                w_addr = r_addr + c_one;
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
        if (!rst_n) begin
            w_we = 1'b0;
        end
    end

    data_memory #(.ADDR_W(ADDR_W)) u_data_memory (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= ST_IDLE;
            r_addr            <= '0;
            r_dlo             <= '0;
            r_mlo             <= '0;
            r_wb              <= 1'b0;
            r_wba             <= '0;
            Stall             <= 1'b0;
            SP_Extra          <= 1'b0;
            WB_Out            <= 1'b0;
            WB_Address_Out    <= '0;
            WB_Data           <= '0;
            PC_Load           <= 1'b0;
            PC_Out            <= '0;
            MEM_Stack_Flags   <= 1'b0;
            Flags_From_Memory <= '0;
        end else begin
            SP_Extra          <= 1'b0;
            WB_Out            <= 1'b0;
            PC_Load           <= 1'b0;
            PC_Out            <= '0;
            MEM_Stack_Flags   <= 1'b0;
            Flags_From_Memory <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (Valid_In) begin
                        if (w_pc_op) begin
                            // WB fields are held back until the second cycle so WB_Out never overlaps Stall
                            r_addr  <= Address[ADDR_W-1:0];
                            r_dlo   <= Data[15:0];
                            r_mlo   <= w_rdata;
                            r_wb    <= WB;
                            r_wba   <= WB_Address;
                            Stall   <= 1'b1;
                            r_state <= MW ? ST_PUSH_LO : ST_POP_HI;
                        end else begin
                            WB_Out         <= WB;
                            WB_Address_Out <= WB_Address;
                            WB_Data        <= Data[15:0];
                            if (MR && !MW) begin
                                if (Stack_Flags) begin
                                    MEM_Stack_Flags   <= 1'b1;
                                    Flags_From_Memory <= w_rdata[NF_BIT:ZF_BIT];
                                end else begin
                                    WB_Data <= w_rdata;
                                end
                            end
                        end
                    end
                end
                ST_PUSH_LO, ST_POP_HI: begin
                    Stall          <= 1'b0;
                    SP_Extra       <= 1'b1;
                    WB_Out         <= r_wb;
                    WB_Address_Out <= r_wba;
                    WB_Data        <= r_dlo;
                    if (r_state == ST_POP_HI) begin
                        PC_Load <= 1'b1;
                        PC_Out  <= {w_rdata, r_mlo};
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    Stall   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed vectors against a transaction-level model of the MEM stage.
// Revision 1.0
`default_nettype none

module tb_memory_stage;

    logic        clk;
    logic        rst_n;
    logic        Valid_In, MR, MW, WB, SP, SPOP, JWSP, Stack_PC, Stack_Flags;
    logic [31:0] Data, Address;
    logic [2:0]  WB_Address, Final_Flags;
    logic        Stall, SP_Extra, WB_Out, PC_Load, MEM_Stack_Flags;
    logic [2:0]  WB_Address_Out, Flags_From_Memory;
    logic [15:0] WB_Data;
    logic [31:0] PC_Out;

    // Expected outputs, advanced by the stimulus process right after each rising edge
    logic        e_stall, e_spx, e_wbo, e_pcl, e_msf;
    logic [2:0]  e_wba, e_ffm;
    logic [15:0] e_wbd;
    logic [31:0] e_pco;
    logic [15:0] mm [0:2047];
    logic        chk_en;
    int          n_vec;
    int          n_err;

    memory_stage #(.ADDR_W(11)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .Valid_In          (Valid_In),
        .Data              (Data),
        .Address           (Address),
        .MR                (MR),
        .MW                (MW),
        .WB                (WB),
        .SP                (SP),
        .SPOP              (SPOP),
        .JWSP              (JWSP),
        .Stack_PC          (Stack_PC),
        .Stack_Flags       (Stack_Flags),
        .WB_Address        (WB_Address),
        .Final_Flags       (Final_Flags),
        .Stall             (Stall),
        .SP_Extra          (SP_Extra),
        .WB_Out            (WB_Out),
        .WB_Address_Out    (WB_Address_Out),
        .WB_Data           (WB_Data),
        .PC_Load           (PC_Load),
        .PC_Out            (PC_Out),
        .MEM_Stack_Flags   (MEM_Stack_Flags),
        .Flags_From_Memory (Flags_From_Memory)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("Stall", Stall, e_stall);
            check("SP_Extra", SP_Extra, e_spx);
            check("WB_Out", WB_Out, e_wbo);
            check("WB_Address_Out", WB_Address_Out, e_wba);
            check("WB_Data", WB_Data, e_wbd);
            check("PC_Load", PC_Load, e_pcl);
            check("PC_Out", PC_Out, e_pco);
            check("MEM_Stack_Flags", MEM_Stack_Flags, e_msf);
            check("Flags_From_Memory", Flags_From_Memory, e_ffm);
        end
    end

    task automatic clear_all_expect();
        e_stall = 0; e_spx = 0; e_wbo = 0; e_pcl = 0; e_msf = 0;
        e_wba = 0; e_ffm = 0; e_wbd = 0; e_pco = 0;
    endtask

    task automatic drive(input logic v, mr, mw, spc, sfl, wb, input logic [2:0] wba,
                         input logic [31:0] d, a, input logic [2:0] fl);
        Valid_In = v; MR = mr; MW = mw; Stack_PC = spc; Stack_Flags = sfl; WB = wb;
        WB_Address = wba; Data = d; Address = a; Final_Flags = fl;
    endtask

    // One instruction: apply, step the edge(s) it needs, update the model's view of memory/outputs
    task automatic issue(input logic v, mr, mw, spc, sfl, wb, input logic [2:0] wba,
                         input logic [31:0] d, a, input logic [2:0] fl);
        logic [10:0] ad;
        logic [15:0] lo;
        ad = a[10:0];
        lo = 16'h0;
        drive(v, mr, mw, spc, sfl, wb, wba, d, a, fl);
        @(posedge clk); #1;
        e_spx = 0; e_pcl = 0; e_pco = 0; e_msf = 0; e_ffm = 0; e_wbo = 0; e_stall = 0;
        if (v) begin
            if (spc && (mr || mw)) begin
                e_stall = 1;
                if (mw) mm[ad] = d[31:16];
                else    lo = mm[ad];
                // The stage must ignore whatever upstream shows while stalled
                drive(1, 1, 1, 0, 1, 1, 3'd7, $urandom, $urandom, 3'b111);
                @(posedge clk); #1;
                e_stall = 0; e_spx = 1;
                e_wbo = wb; e_wba = wba; e_wbd = d[15:0];
                if (mw) begin
                    mm[ad - 11'd1] = d[15:0];
                end else begin
                    e_pcl = 1;
                    e_pco = {mm[ad + 11'd1], lo};
                end
            end else begin
                e_wbo = wb; e_wba = wba; e_wbd = d[15:0];
                if (mw) begin
                    mm[ad] = sfl ? {13'b0, fl} : d[15:0];
                end else if (mr) begin
                    if (sfl) begin
                        e_msf = 1;
                        e_ffm = mm[ad][2:0];
                    end else begin
                        e_wbd = mm[ad];
                    end
                end
            end
        end
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] wba);
        issue(1, 1, 0, 0, 0, 1, wba, 32'h0, a, 3'b0);
    endtask

    initial begin
        n_vec = 0; n_err = 0; chk_en = 0;
        SP = 0; SPOP = 0; JWSP = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        clear_all_expect();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_en = 1;
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Store then load, plus a non-memory op and MR+MW priority
        issue(1, 0, 1, 0, 0, 0, 3'd0, 32'h0000BEEF, 32'd5, 3'b0);
        load(32'd5, 3'd3);
        check("lit_load_data", WB_Data, 32'hBEEF);
        check("lit_load_wba", WB_Address_Out, 32'd3);
        issue(1, 0, 0, 0, 0, 1, 3'd6, 32'h1234ABCD, 32'd99, 3'b0);
        check("lit_alu_data", WB_Data, 32'hABCD);
        issue(1, 1, 1, 0, 0, 0, 3'd0, 32'h00000077, 32'd6, 3'b0);
        load(32'd6, 3'd1);
        check("lit_mrmw_store", WB_Data, 32'h0077);

        // PC push at top of memory, readback, then pop
        issue(1, 0, 1, 1, 0, 0, 3'd0, 32'h00012345, 32'h7FF, 3'b0);
        check("lit_push_spx", SP_Extra, 32'd1);
        load(32'h7FF, 3'd2);
        check("lit_push_hi", WB_Data, 32'h0001);
        load(32'h7FE, 3'd2);
        check("lit_push_lo", WB_Data, 32'h2345);
        issue(1, 1, 0, 1, 0, 0, 3'd0, 32'h0, 32'h7FE, 3'b0);
        check("lit_pop_load", PC_Load, 32'd1);
        check("lit_pop_pc", PC_Out, 32'h00012345);

        // Wrap of A-1 at address 0
        issue(1, 0, 1, 1, 0, 0, 3'd0, 32'hAAAA5555, 32'h0, 3'b0);
        load(32'h0, 3'd4);
        check("lit_wrap_hi", WB_Data, 32'hAAAA);
        load(32'h7FF, 3'd4);
        check("lit_wrap_lo", WB_Data, 32'h5555);

        // Flags push/pop; the pulse lasts one cycle
        issue(1, 0, 1, 0, 1, 0, 3'd0, 32'h0000FFFF, 32'd10, 3'b101);
        issue(1, 1, 0, 0, 1, 0, 3'd0, 32'h0, 32'd10, 3'b0);
        check("lit_flags_pulse", MEM_Stack_Flags, 32'd1);
        check("lit_flags_val", Flags_From_Memory, 32'b101);
        issue(0, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 3'b0);
        check("lit_flags_drop", MEM_Stack_Flags, 32'd0);

        // Stack_PC wins over Stack_Flags
        issue(1, 0, 1, 1, 1, 1, 3'd5, 32'h0BADF00D, 32'h100, 3'b010);
        issue(1, 1, 0, 1, 1, 0, 3'd0, 32'h0, 32'h0FF, 3'b0);
        check("lit_both_pc", PC_Out, 32'h0BADF00D);

        // Bubble with MW set
        issue(0, 0, 1, 0, 0, 1, 3'd2, 32'h00009999, 32'd5, 3'b0);
        check("lit_bubble_wb", WB_Out, 32'd0);
        load(32'd5, 3'd0);
        check("lit_bubble_mem", WB_Data, 32'hBEEF);

        // Reset during PUSH_LO abandons the second word
        issue(1, 0, 1, 0, 0, 0, 3'd0, 32'h00001111, 32'h1F, 3'b0);
        drive(1, 0, 1, 1, 0, 0, 3'd0, 32'h22223333, 32'h20, 3'b0);
        @(posedge clk); #1;
        mm[11'h20] = 16'h2222;
        e_stall = 1; e_spx = 0; e_wbo = 0; e_pcl = 0; e_pco = 0; e_msf = 0; e_ffm = 0;
        #2;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        clear_all_expect();
        #1;
        check("lit_rst_stall", Stall, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        load(32'h1F, 3'd6);
        check("lit_rst_keep", WB_Data, 32'h1111);
        load(32'h20, 3'd6);
        check("lit_rst_first", WB_Data, 32'h2222);

        issue(0, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 3'b0);
        issue(0, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 3'b0);
        @(negedge clk);
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
